// File: rtl/wb_arbiter.sv
// Write-back arbiter for the integer register file: round-robin between the ALU and LSU
// write-back ports, a registered write port, and a per-register in-flight scoreboard for decode.
module wb_arbiter #(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        I_iss_valid,
  input  logic [4:0]  I_iss_rd,
  output logic        O_iss_ready,
  input  logic [4:0]  I_rs1_raddr,
  input  logic [4:0]  I_rs2_raddr,
  output logic        O_rs1_busy,
  output logic        O_rs2_busy,
  input  logic        I_a_valid,
  input  logic [4:0]  I_a_waddr,
  input  logic [31:0] I_a_wdata,
  output logic        O_a_ready,
  input  logic        I_l_valid,
  input  logic [4:0]  I_l_waddr,
  input  logic [31:0] I_l_wdata,
  output logic        O_l_ready,
  output logic        O_rd_we,
  output logic [4:0]  O_rd_waddr,
  output logic [31:0] O_rd_wdata
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [32];
  logic             rr_q, rr_d;
  logic             grant_a, grant_l, cmt_valid, iss_fire;
  logic [4:0]       cmt_addr;
  logic [31:0]      cmt_data;
  logic [31:0]      inc_vec, dec_vec;
  logic             rd_we_q;
  logic [4:0]       rd_waddr_q;
  logic [31:0]      rd_wdata_q;

  // Ready comes from the grant alone; the requesters are never stalled by anything else.
  assign grant_a   = I_a_valid && (!I_l_valid || !rr_q);
  assign grant_l   = I_l_valid && (!I_a_valid ||  rr_q);
  assign O_a_ready = grant_a;
  assign O_l_ready = grant_l;
  assign cmt_valid = grant_a || grant_l;
  assign cmt_addr  = grant_a ? I_a_waddr : I_l_waddr;
  assign cmt_data  = grant_a ? I_a_wdata : I_l_wdata;

  // Saturation looks at the pre-update count, so a same-cycle commit cannot unblock an issue.
  assign O_iss_ready = (I_iss_rd == 5'd0) || (cnt_q[I_iss_rd] != CNT_MAX);
  assign iss_fire    = I_iss_valid && O_iss_ready && (I_iss_rd != 5'd0);

  assign O_rs1_busy = (I_rs1_raddr != 5'd0) && (cnt_q[I_rs1_raddr] != '0);
  assign O_rs2_busy = (I_rs2_raddr != 5'd0) && (cnt_q[I_rs2_raddr] != '0);

  always_comb begin
    // NOTE: every combinationally written signal gets a default first so no latch is inferred.
    inc_vec = '0;
    dec_vec = '0;
    rr_d    = rr_q;
    if (iss_fire)
      inc_vec[I_iss_rd] = 1'b1;
    // Underflow guard: a commit to an idle register is a requester error and leaves the count at 0.
    if (cmt_valid && (cmt_addr != 5'd0) && (cnt_q[cmt_addr] != '0))
      dec_vec[cmt_addr] = 1'b1;
    if (I_a_valid && I_l_valid)
      rr_d = !rr_q;
  end

  // NOTE: the counters are state that decode depends on right after reset, so the whole array
  // is reset asynchronously rather than treated as an uninitialised memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          cnt_q[r] <= cnt_q[r] + CNT_ONE;
        else if (dec_vec[r] && !inc_vec[r])
          cnt_q[r] <= cnt_q[r] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q       <= 1'b0;
      rd_we_q    <= 1'b0;
      rd_waddr_q <= 5'd0;
      rd_wdata_q <= 32'd0;
    end else begin
      rr_q <= rr_d;
      if (cmt_valid) begin
        rd_we_q    <= (cmt_addr != 5'd0);
        rd_waddr_q <= cmt_addr;
        rd_wdata_q <= cmt_data;
      end else begin
        rd_we_q    <= 1'b0;
      end
    end
  end

  assign O_rd_we    = rd_we_q;
  assign O_rd_waddr = rd_waddr_q;
  assign O_rd_wdata = rd_wdata_q;

  // A commit to a register with no write in flight means a requester broke its contract.
  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    (cmt_valid && (cmt_addr != 5'd0)) |-> (cnt_q[cmt_addr] != '0));

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by randomized traffic, all checked against
// a per-register in-flight count model with a preferred-source flag.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        I_iss_valid;
  logic [4:0]  I_iss_rd;
  logic        O_iss_ready;
  logic [4:0]  I_rs1_raddr, I_rs2_raddr;
  logic        O_rs1_busy, O_rs2_busy;
  logic        I_a_valid, I_l_valid;
  logic [4:0]  I_a_waddr, I_l_waddr;
  logic [31:0] I_a_wdata, I_l_wdata;
  logic        O_a_ready, O_l_ready;
  logic        O_rd_we;
  logic [4:0]  O_rd_waddr;
  logic [31:0] O_rd_wdata;

  wb_arbiter #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .I_iss_valid(I_iss_valid), .I_iss_rd(I_iss_rd), .O_iss_ready(O_iss_ready),
    .I_rs1_raddr(I_rs1_raddr), .I_rs2_raddr(I_rs2_raddr),
    .O_rs1_busy(O_rs1_busy), .O_rs2_busy(O_rs2_busy),
    .I_a_valid(I_a_valid), .I_a_waddr(I_a_waddr), .I_a_wdata(I_a_wdata), .O_a_ready(O_a_ready),
    .I_l_valid(I_l_valid), .I_l_waddr(I_l_waddr), .I_l_wdata(I_l_wdata), .O_l_ready(O_l_ready),
    .O_rd_we(O_rd_we), .O_rd_waddr(O_rd_waddr), .O_rd_wdata(O_rd_wdata)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cnt_m [32];
  bit          lsu_pref;
  bit          ga, gl;
  logic        exp_we;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (cnt_m[i]) cnt_m[i] = 0;
    lsu_pref  = 1'b0;
    exp_we    = 1'b0;
    exp_waddr = 5'd0;
    exp_wdata = 32'd0;
  endtask

  task automatic set_iss(input logic v, input logic [4:0] rd);
    I_iss_valid = v; I_iss_rd = rd;
  endtask
  task automatic set_a(input logic v, input logic [4:0] a, input logic [31:0] d);
    I_a_valid = v; I_a_waddr = a; I_a_wdata = d;
  endtask
  task automatic set_l(input logic v, input logic [4:0] a, input logic [31:0] d);
    I_l_valid = v; I_l_waddr = a; I_l_wdata = d;
  endtask
  task automatic idle();
    set_iss(1'b0, 5'd0); set_a(1'b0, 5'd0, 32'd0); set_l(1'b0, 5'd0, 32'd0);
  endtask

  // One clock: check combinational outputs against the model, step the model at the edge,
  // then check the registered write port.
  task automatic cycle();
    int          rd, r1, r2, wa;
    bit          iss_rdy, iss_ok, dec_ok, both;
    logic [31:0] wd;
    #1;
    rd = int'(I_iss_rd);
    r1 = int'(I_rs1_raddr);
    r2 = int'(I_rs2_raddr);
    iss_rdy = (rd == 0) || (cnt_m[rd] < 3);
    iss_ok  = I_iss_valid && iss_rdy && (rd != 0);
    both    = I_a_valid && I_l_valid;
    ga      = I_a_valid && !(I_l_valid && lsu_pref);
    gl      = I_l_valid && !ga;
    wa      = ga ? int'(I_a_waddr) : int'(I_l_waddr);
    wd      = ga ? I_a_wdata : I_l_wdata;
    dec_ok  = (ga || gl) && (wa != 0) && (cnt_m[wa] > 0);
    check("iss_ready", 32'(O_iss_ready), 32'(iss_rdy));
    check("a_ready",   32'(O_a_ready),   32'(ga));
    check("l_ready",   32'(O_l_ready),   32'(gl));
    check("rs1_busy",  32'(O_rs1_busy),  32'((r1 != 0) && (cnt_m[r1] > 0)));
    check("rs2_busy",  32'(O_rs2_busy),  32'((r2 != 0) && (cnt_m[r2] > 0)));
    @(posedge clk);
    if (iss_ok) cnt_m[rd]++;
    if (dec_ok) cnt_m[wa]--;
    if (both) lsu_pref = !lsu_pref;
    exp_we = (ga || gl) && (wa != 0);
    if (ga || gl) begin
      exp_waddr = 5'(wa);
      exp_wdata = wd;
    end
    #1;
    check("rd_we",    32'(O_rd_we),    32'(exp_we));
    check("rd_waddr", 32'(O_rd_waddr), 32'(exp_waddr));
    check("rd_wdata", O_rd_wdata,      exp_wdata);
  endtask

  bit          a_req, l_req;
  logic [4:0]  a_addr, l_addr;
  logic [31:0] a_dat, l_dat;
  int          claims [32];

  initial begin
    rst = 1'b1;
    idle();
    I_rs1_raddr = 5'd0; I_rs2_raddr = 5'd0;
    model_reset();
    #2;
    check("reset_we",    32'(O_rd_we),     32'd0);
    check("reset_waddr", 32'(O_rd_waddr),  32'd0);
    check("reset_wdata", O_rd_wdata,       32'd0);
    check("reset_iss",   32'(O_iss_ready), 32'd1);
    check("reset_a_rdy", 32'(O_a_ready),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single ALU write-back to x7.
    set_iss(1'b1, 5'd7); cycle();
    set_iss(1'b0, 5'd0); set_a(1'b1, 5'd7, 32'hDEADBEEF); I_rs1_raddr = 5'd7; cycle();
    check("alu_we",    32'(O_rd_we),    32'd1);
    check("alu_waddr", 32'(O_rd_waddr), 32'd7);
    check("alu_wdata", O_rd_wdata,      32'hDEADBEEF);
    set_a(1'b0, 5'd0, 32'd0); #1;
    check("alu_busy_clear", 32'(O_rs1_busy), 32'd0);

    // Round-robin under continuous dual requests to x1, with a fourth issue slotted in.
    for (int k = 0; k < 3; k++) begin set_iss(1'b1, 5'd1); cycle(); end
    set_a(1'b1, 5'd1, 32'hA0); set_l(1'b1, 5'd1, 32'hB0); I_rs1_raddr = 5'd1;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) set_iss(1'b1, 5'd1); else set_iss(1'b0, 5'd0);
      cycle();
      check("rr_we",    32'(O_rd_we), 32'd1);
      check("rr_wdata", O_rd_wdata,   (k % 2 == 0) ? 32'hA0 + 32'(k / 2) : 32'hB0 + 32'(k / 2));
      if (k % 2 == 0) I_a_wdata = 32'hA1; else I_l_wdata = 32'hB1;
    end
    idle(); #1;
    check("rr_busy_clear", 32'(O_rs1_busy), 32'd0);

    // Saturation on x3: a same-cycle commit does not unblock the refused issue.
    for (int k = 0; k < 3; k++) begin set_iss(1'b1, 5'd3); cycle(); end
    set_a(1'b1, 5'd3, 32'h33); #1;
    check("sat_refused", 32'(O_iss_ready), 32'd0);
    cycle();
    set_a(1'b0, 5'd0, 32'd0); #1;
    check("sat_accepted", 32'(O_iss_ready), 32'd1);
    cycle();
    set_iss(1'b0, 5'd0);
    for (int k = 0; k < 3; k++) begin set_a(1'b1, 5'd3, 32'h300 + 32'(k)); cycle(); end
    idle();

    // x0: issue and commit have no scoreboard effect and no register-file write.
    set_iss(1'b1, 5'd0); set_a(1'b1, 5'd0, 32'h1234); I_rs1_raddr = 5'd0; #1;
    check("x0_iss_ready", 32'(O_iss_ready), 32'd1);
    check("x0_busy",      32'(O_rs1_busy),  32'd0);
    cycle();
    check("x0_we",    32'(O_rd_we),  32'd0);
    check("x0_wdata", O_rd_wdata,    32'h1234);
    idle();

    // Same-cycle issue and commit on x9 nets to zero.
    set_iss(1'b1, 5'd9); cycle();
    set_l(1'b1, 5'd9, 32'h99); I_rs2_raddr = 5'd9; cycle();
    idle(); #1;
    check("x9_still_busy", 32'(O_rs2_busy), 32'd1);
    set_l(1'b1, 5'd9, 32'h98); cycle();
    idle(); #1;
    check("x9_clear", 32'(O_rs2_busy), 32'd0);

    // Mid-stream reset with cnt[5]=2, a write on the port and the LSU preferred.
    set_iss(1'b1, 5'd6); cycle(); cycle();
    set_iss(1'b1, 5'd5); cycle(); cycle();
    set_iss(1'b0, 5'd0); set_a(1'b1, 5'd6, 32'h66); set_l(1'b1, 5'd6, 32'h67); cycle();
    #2 rst = 1'b1;
    #1;
    check("mid_reset_we",    32'(O_rd_we),    32'd0);
    check("mid_reset_waddr", 32'(O_rd_waddr), 32'd0);
    idle(); model_reset(); I_rs1_raddr = 5'd5;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_busy5", 32'(O_rs1_busy), 32'd0);
    set_iss(1'b1, 5'd8); cycle(); cycle();
    set_iss(1'b0, 5'd0); set_a(1'b1, 5'd8, 32'h80); set_l(1'b1, 5'd8, 32'h81); #1;
    check("post_reset_rr_a", 32'(O_a_ready), 32'd1);
    check("post_reset_rr_l", 32'(O_l_ready), 32'd0);
    cycle();
    set_a(1'b0, 5'd0, 32'd0); cycle();
    idle();

    // Randomized traffic; requesters only target registers with an uncommitted write to spare.
    a_req = 1'b0; l_req = 1'b0;
    a_addr = 5'd0; l_addr = 5'd0; a_dat = 32'd0; l_dat = 32'd0;
    foreach (claims[i]) claims[i] = 0;
    for (int i = 0; i < 400; i++) begin
      int r;
      if (!a_req && $urandom_range(0, 2) != 0) begin
        r = int'($urandom_range(0, 7));
        if (r == 0 || cnt_m[r] - claims[r] > 0) begin
          a_req = 1'b1; a_addr = 5'(r); a_dat = $urandom;
          if (r != 0) claims[r]++;
        end
      end
      if (!l_req && $urandom_range(0, 2) != 0) begin
        r = int'($urandom_range(0, 7));
        if (r == 0 || cnt_m[r] - claims[r] > 0) begin
          l_req = 1'b1; l_addr = 5'(r); l_dat = $urandom;
          if (r != 0) claims[r]++;
        end
      end
      set_a(a_req, a_addr, a_dat);
      set_l(l_req, l_addr, l_dat);
      set_iss(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
      I_rs1_raddr = 5'($urandom_range(0, 7));
      I_rs2_raddr = 5'($urandom_range(0, 7));
      cycle();
      if (ga) begin a_req = 1'b0; if (a_addr != 5'd0) claims[int'(a_addr)]--; end
      if (gl) begin l_req = 1'b0; if (l_addr != 5'd0) claims[int'(l_addr)]--; end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
